alu_cmd_sequencer: RTL and testbench

//  - Initiator side of the 4-bit ALU interface: takes {opcode, A, B} commands over valid/ready, drives the ALU operand/opcode

---
 rtl/alu_cmd_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: initiator side of the 4-bit ALU interface.
// Accepts one {opcode, A, B} command at a time and drives registered operands into
// the ALU. It waits ALU_LAT cycles, then captures the result and flags into a
// response that is held until the consumer takes it.
// Optional feature: define ALU_STICKY_FLAGS_EN to add the sticky_flags/clr_sticky
// ports. sticky_flags accumulates (ORs) every captured flag set.
module alu_cmd_sequencer #(
  parameter int WIDTH   = 4,
  parameter int OP_W    = 3,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_chain,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [OP_W-1:0]  alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [3:0]       rsp_flags,
  output logic             busy
`ifdef ALU_STICKY_FLAGS_EN
  ,
  output logic [3:0]       sticky_flags,
  input  logic             clr_sticky
`endif
);

  // ALU_LAT is legal up to 15, so a 4-bit down-counter covers every setting.
  localparam int              CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   in1_q, in1_d;
  logic [WIDTH-1:0]   in2_q, in2_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [3:0]         rsp_flags_q, rsp_flags_d;
  logic [WIDTH-1:0]   last_q, last_d;
  logic               capture;
`ifdef ALU_STICKY_FLAGS_EN
  logic [3:0]         sticky_q, sticky_d;
`endif

  // Next-state and datapath updates: accept in IDLE, count down in WAIT, hold in RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    last_d      = last_q;
    capture     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          // Chaining substitutes the last captured result for operand A.
          in1_d   = cmd_chain ? last_q : cmd_a;
          in2_d   = cmd_b;
          op_d    = cmd_op;
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          capture     = 1'b1;
          rsp_data_d  = alu_out;
          rsp_flags_d = alu_flags;
          last_d      = alu_out;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        // No bypass back to accept: cmd_ready only returns after this handshake edge.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ALU_STICKY_FLAGS_EN
  // Sticky flag accumulation; a capture ORs new flags in even when a clear arrives together.
  always_comb begin
    sticky_d = sticky_q;
    if (capture) begin
      sticky_d = (clr_sticky ? 4'b0000 : sticky_q) | alu_flags;
    end else if (clr_sticky) begin
      sticky_d = 4'b0000;
    end
  end
`endif

  // State register with synchronous active-low reset; a reset drops any in-flight work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      last_q      <= '0;
`ifdef ALU_STICKY_FLAGS_EN
      sticky_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      last_q      <= last_d;
`ifdef ALU_STICKY_FLAGS_EN
      sticky_q    <= sticky_d;
`endif
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign alu_in1    = in1_q;
  assign alu_in2    = in2_q;
  assign alu_opcode = op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
`ifdef ALU_STICKY_FLAGS_EN
  assign sticky_flags = sticky_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: pairs alu_cmd_sequencer with a 4-bit ALU model.
// u1 uses ALU_LAT=1 and u3 uses ALU_LAT=3.
// A queue-based response model checks u1 on every cycle.
// Directed sequences carry hand-computed literal expectations.
// The sticky-flag section exists only when ALU_STICKY_FLAGS_EN is defined.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // 4-bit ALU: returns {flags[3:0] = {neg, zero, ovf, carry}, result[3:0]}
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic       c;
    logic       v;
    s = 5'd0; r = 4'd0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
      3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ~a;
      3'd5: r = a ^ b;
      3'd6: begin r = ~a + 4'd1; v = (a == 4'b1000); end
      default: begin r = {a[2:0], 1'b0}; c = a[3]; v = a[3] ^ a[2]; end
    endcase
    return {r[3], (r == 4'd0), v, c, r};
  endfunction

  // ---------------- u1 (ALU_LAT = 1) ----------------
  logic       rst1_n, v1, ch1, rr1;
  logic [2:0] op1, aop1;
  logic [3:0] a1, b1;
  logic       rdy1, rv1, busy1;
  logic [3:0] in1_1, in2_1, rd1, rf1, ao1, af1;
  logic [7:0] alu1_res;
  logic       force_en;
  logic [3:0] force_flags;
  assign alu1_res = alu_f(aop1, in1_1, in2_1);
  assign ao1      = alu1_res[3:0];
  assign af1      = force_en ? force_flags : alu1_res[7:4];
`ifdef ALU_STICKY_FLAGS_EN
  logic [3:0] st1, st3;
  logic       clr1, clr3;
`endif

  alu_cmd_sequencer #(.WIDTH(4), .OP_W(3), .ALU_LAT(1)) u1 (
    .clk(clk), .rst_n(rst1_n), .cmd_valid(v1), .cmd_ready(rdy1), .cmd_op(op1),
    .cmd_a(a1), .cmd_b(b1), .cmd_chain(ch1), .alu_in1(in1_1), .alu_in2(in2_1),
    .alu_opcode(aop1), .alu_out(ao1), .alu_flags(af1), .rsp_valid(rv1),
    .rsp_ready(rr1), .rsp_data(rd1), .rsp_flags(rf1), .busy(busy1)
`ifdef ALU_STICKY_FLAGS_EN
    , .sticky_flags(st1), .clr_sticky(clr1)
`endif
  );

  // ---------------- u3 (ALU_LAT = 3) ----------------
  logic       rst3_n, v3, ch3, rr3;
  logic [2:0] op3, aop3;
  logic [3:0] a3, b3;
  logic       rdy3, rv3, busy3;
  logic [3:0] in1_3, in2_3, rd3, rf3, ao3, af3;
  logic [7:0] alu3_res;
  assign alu3_res = alu_f(aop3, in1_3, in2_3);
  assign ao3      = alu3_res[3:0];
  assign af3      = alu3_res[7:4];

  alu_cmd_sequencer #(.WIDTH(4), .OP_W(3), .ALU_LAT(3)) u3 (
    .clk(clk), .rst_n(rst3_n), .cmd_valid(v3), .cmd_ready(rdy3), .cmd_op(op3),
    .cmd_a(a3), .cmd_b(b3), .cmd_chain(ch3), .alu_in1(in1_3), .alu_in2(in2_3),
    .alu_opcode(aop3), .alu_out(ao3), .alu_flags(af3), .rsp_valid(rv3),
    .rsp_ready(rr3), .rsp_data(rd3), .rsp_flags(rf3), .busy(busy3)
`ifdef ALU_STICKY_FLAGS_EN
    , .sticky_flags(st3), .clr_sticky(clr3)
`endif
  );

  // ---------------- behavioural model of u1 ----------------
  // One outstanding command at most; its expected response is queued when it is accepted.
  logic [7:0] exp_q[$];
  logic [3:0] m_last, m_a, m_b;
  logic [2:0] m_op;
  logic       m_busy;

  always @(posedge clk) begin
    logic [7:0] r;
    if (rst1_n !== 1'b1) begin
      exp_q.delete();
      m_last = 4'd0;
      m_busy = 1'b0;
    end else begin
      if (rv1 && rr1 && m_busy) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_busy = 1'b0;
      end
      if (v1 && rdy1) begin
        m_a  = ch1 ? m_last : a1;
        m_b  = b1;
        m_op = op1;
        r    = alu_f(m_op, m_a, m_b);
        if (force_en) r[7:4] = force_flags;
        exp_q.push_back(r);
        m_last = r[3:0];
        m_busy = 1'b1;
      end
    end
  end

  // Compare u1 against the model on every falling edge outside reset.
  always @(negedge clk) begin
    if (rst1_n === 1'b1) begin
      chk("model_busy", 32'(busy1), 32'(m_busy));
      chk("model_cmd_ready", 32'(rdy1), 32'(!m_busy));
      if (rv1) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rv1), 32'd0);
        else begin
          chk("model_rsp_data", 32'(rd1), 32'(exp_q[0][3:0]));
          chk("model_rsp_flags", 32'(rf1), 32'(exp_q[0][7:4]));
        end
      end
      if (m_busy) begin
        chk("model_alu_in1", 32'(in1_1), 32'(m_a));
        chk("model_alu_in2", 32'(in2_1), 32'(m_b));
        chk("model_alu_opcode", 32'(aop1), 32'(m_op));
      end
    end
  end

  // Present a command on u1 (caller is just past a falling edge); returns at the
  // falling edge after the accepting rising edge.
  task automatic issue1(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic ch);
    int w;
    v1 = 1'b1; op1 = op; a1 = a; b1 = b; ch1 = ch;
    w = 0;
    while (!rdy1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!rdy1) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
  endtask

  task automatic wait_rv1();
    int w;
    w = 0;
    while (!rv1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!rv1) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       ch;
    logic [3:0] d;
    logic [3:0] f;
  } vec_t;
  vec_t vt[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    vt[0] = '{op: 3'd4, a: 4'b0110, b: 4'b0000, ch: 1'b0, d: 4'b1001, f: 4'b1000};
    vt[1] = '{op: 3'd6, a: 4'b0011, b: 4'b0000, ch: 1'b0, d: 4'b1101, f: 4'b1000};
    vt[2] = '{op: 3'd7, a: 4'b1011, b: 4'b0000, ch: 1'b0, d: 4'b0110, f: 4'b0011};
    vt[3] = '{op: 3'd0, a: 4'b1111, b: 4'b0111, ch: 1'b1, d: 4'b1101, f: 4'b1010};
    vt[4] = '{op: 3'd1, a: 4'b0010, b: 4'b0011, ch: 1'b0, d: 4'b1111, f: 4'b1000};
    vt[5] = '{op: 3'd2, a: 4'b1010, b: 4'b0101, ch: 1'b0, d: 4'b0000, f: 4'b0100};

    rst1_n = 1'b0; v1 = 1'b0; ch1 = 1'b0; rr1 = 1'b1; op1 = 3'd0; a1 = 4'd0; b1 = 4'd0;
    rst3_n = 1'b0; v3 = 1'b0; ch3 = 1'b0; rr3 = 1'b1; op3 = 3'd0; a3 = 4'd0; b3 = 4'd0;
    force_en = 1'b0; force_flags = 4'd0;
`ifdef ALU_STICKY_FLAGS_EN
    clr1 = 1'b0; clr3 = 1'b0;
`endif
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cmd_ready", 32'(rdy1), 32'd1);
    chk("rst_rsp_valid", 32'(rv1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_alu_in1", 32'(in1_1), 32'd0);
    chk("rst_alu_in2", 32'(in2_1), 32'd0);
    chk("rst_alu_opcode", 32'(aop1), 32'd0);
    chk("rst_rsp_data", 32'(rd1), 32'd0);
    chk("rst_rsp_flags", 32'(rf1), 32'd0);
    chk("rst3_cmd_ready", 32'(rdy3), 32'd1);
`ifdef ALU_STICKY_FLAGS_EN
    chk("rst_sticky", 32'(st1), 32'd0);
`endif
    rst1_n = 1'b1; rst3_n = 1'b1;
    @(negedge clk);

    // add 3+5: response one cycle after accept
    issue1(3'd0, 4'd3, 4'd5, 1'b0);
    chk("add_rv_early", 32'(rv1), 32'd0);
    chk("add_busy", 32'(busy1), 32'd1);
    chk("add_ready_low", 32'(rdy1), 32'd0);
    @(negedge clk);
    chk("add_rv", 32'(rv1), 32'd1);
    chk("add_data", 32'(rd1), 32'b1000);
    chk("add_flags", 32'(rf1), 32'b1010);
    @(negedge clk);
    chk("add_rv_drop", 32'(rv1), 32'd0);
    chk("add_ready_back", 32'(rdy1), 32'd1);

    // chain: A replaced by last result 4'b1000
    issue1(3'd2, 4'b0001, 4'b1100, 1'b1);
    chk("chain_alu_in1", 32'(in1_1), 32'b1000);
    @(negedge clk);
    chk("chain_data", 32'(rd1), 32'b1000);
    chk("chain_flags", 32'(rf1), 32'b1000);
    @(negedge clk);

    // sub 5-5
    issue1(3'd1, 4'd5, 4'd5, 1'b0);
    @(negedge clk);
    chk("sub_data", 32'(rd1), 32'd0);
    chk("sub_flags", 32'(rf1), 32'b0101);
    @(negedge clk);

    // backpressure: response held, second command waits for the handshake
    rr1 = 1'b0;
    issue1(3'd5, 4'b1010, 4'b0110, 1'b0);
    @(negedge clk);
    chk("bp_rv", 32'(rv1), 32'd1);
    v1 = 1'b1; op1 = 3'd3; a1 = 4'b0001; b1 = 4'b0010; ch1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_rv_hold", 32'(rv1), 32'd1);
      chk("bp_data_hold", 32'(rd1), 32'b1100);
      chk("bp_ready_low", 32'(rdy1), 32'd0);
    end
    rr1 = 1'b1;
    @(negedge clk);
    chk("bp_rv_after_hs", 32'(rv1), 32'd0);
    chk("bp_ready_after_hs", 32'(rdy1), 32'd1);
    @(negedge clk);
    v1 = 1'b0;
    chk("bp_second_in1", 32'(in1_1), 32'b0001);
    chk("bp_second_op", 32'(aop1), 32'd3);
    @(negedge clk);
    chk("bp_second_data", 32'(rd1), 32'b0011);
    @(negedge clk);

    // table of further operations (literal + model)
    for (int i = 0; i < 6; i++) begin
      issue1(vt[i].op, vt[i].a, vt[i].b, vt[i].ch);
      wait_rv1();
      chk($sformatf("vec%0d_data", i), 32'(rd1), 32'(vt[i].d));
      chk($sformatf("vec%0d_flags", i), 32'(rf1), 32'(vt[i].f));
      @(negedge clk);
    end

    // reset while a response is pending: it is dropped
    rr1 = 1'b0;
    issue1(3'd0, 4'd1, 4'd1, 1'b0);
    @(negedge clk);
    rst1_n = 1'b0;
    @(negedge clk);
    rst1_n = 1'b1;
    chk("rstresp_rv", 32'(rv1), 32'd0);
    chk("rstresp_ready", 32'(rdy1), 32'd1);
    rr1 = 1'b1;
    repeat (3) @(negedge clk);

    // chain right after reset uses A = 0
    issue1(3'd0, 4'b0111, 4'b0011, 1'b1);
    chk("chain0_alu_in1", 32'(in1_1), 32'd0);
    @(negedge clk);
    chk("chain0_data", 32'(rd1), 32'b0011);
    @(negedge clk);

`ifdef ALU_STICKY_FLAGS_EN
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    chk("sticky_clr0", 32'(st1), 32'd0);
    force_en = 1'b1; force_flags = 4'b1000;
    issue1(3'd0, 4'd1, 4'd1, 1'b0);
    @(negedge clk);
    chk("sticky_1", 32'(st1), 32'b1000);
    @(negedge clk);
    force_flags = 4'b0010;
    issue1(3'd0, 4'd1, 4'd1, 1'b0);
    @(negedge clk);
    chk("sticky_2", 32'(st1), 32'b1010);
    @(negedge clk);
    force_flags = 4'b0001; clr1 = 1'b1;
    issue1(3'd0, 4'd1, 4'd1, 1'b0);
    @(negedge clk);
    chk("sticky_clr_capture", 32'(st1), 32'b0001);
    clr1 = 1'b0;
    @(negedge clk);
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    chk("sticky_clr_alone", 32'(st1), 32'd0);
    force_en = 1'b0;
`endif

    // ALU_LAT = 3: capture three edges after accept
    v3 = 1'b1; op3 = 3'd0; a3 = 4'd3; b3 = 4'd5; ch3 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v3 = 1'b0;
    chk("lat3_busy", 32'(busy3), 32'd1);
    chk("lat3_rv_n0", 32'(rv3), 32'd0);
    @(negedge clk);
    chk("lat3_rv_n1", 32'(rv3), 32'd0);
    @(negedge clk);
    chk("lat3_rv_n2", 32'(rv3), 32'd0);
    @(negedge clk);
    chk("lat3_rv_n3", 32'(rv3), 32'd1);
    chk("lat3_data", 32'(rd3), 32'b1000);
    chk("lat3_flags", 32'(rf3), 32'b1010);
    @(negedge clk);
    chk("lat3_rv_drop", 32'(rv3), 32'd0);

    // ALU_LAT = 3: reset in WAIT drops the command and the last result
    v3 = 1'b1; op3 = 3'd1; a3 = 4'd7; b3 = 4'd1; ch3 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v3 = 1'b0;
    @(negedge clk);
    chk("lat3_in_wait", 32'(busy3), 32'd1);
    rst3_n = 1'b0;
    @(negedge clk);
    rst3_n = 1'b1;
    chk("lat3_rst_ready", 32'(rdy3), 32'd1);
    chk("lat3_rst_busy", 32'(busy3), 32'd0);
    chk("lat3_rst_rv", 32'(rv3), 32'd0);
    chk("lat3_rst_in1", 32'(in1_3), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("lat3_no_rsp", 32'(rv3), 32'd0);
    end
    v3 = 1'b1; op3 = 3'd0; a3 = 4'b1111; b3 = 4'b0001; ch3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    v3 = 1'b0;
    chk("lat3_chain_in1", 32'(in1_3), 32'd0);
    for (int i = 0; i < 10 && !rv3; i++) @(negedge clk);
    chk("lat3_chain_rv", 32'(rv3), 32'd1);
    chk("lat3_chain_data", 32'(rd3), 32'b0001);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
